// File: rtl/multi_timer.sv
// multi_timer: NCH independent down-counting timers behind a word-addressed register file.
// Latency: register writes land on the next rising edge; Dout is combinational; IRQ follows pending directly.
// Backpressure: none; every read or write completes in the cycle it is presented.
module multi_timer #(
  parameter int NCH   = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  output logic [NCH-1:0]   IRQ,
  output logic             IRQ_any
);

  // Decoded word-address width: enough to reach the STATUS word at 4*NCH.
  localparam int AW  = $clog2(4*NCH+1);
  // Channel-select field width inside the decoded word address.
  localparam int CHW = AW - 2;
  localparam logic [AW-1:0] STATUS_WORD = AW'(4*NCH);

  // Per-channel register offsets inside each 4-word channel window.
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [AW-1:0]  word;
  logic [CHW-1:0] ch_sel;
  logic [1:0]     reg_sel;
  logic           in_ch;
  logic           status_sel;
  logic           status_we;

  // Upper address bits belong to the bridge and Din is only partly consumed
  // for narrow counters; fold them into one sink so intent is explicit.
  logic           unused_bits;

  assign word        = Addr[AW+1:2];
  assign ch_sel      = word[AW-1:2];
  assign reg_sel     = word[1:0];
  assign in_ch       = (word < STATUS_WORD);
  assign status_sel  = (word == STATUS_WORD);
  assign status_we   = WE && status_sel;
  assign unused_bits = ^{Addr, Din};

  // ---------------------------------------------------------------------------
  // Flattened views of per-channel state for the read mux
  // ---------------------------------------------------------------------------
  logic [NCH-1:0][3:0]       ctrl_all;
  logic [NCH-1:0][CNT_W-1:0] preset_all;
  logic [NCH-1:0][CNT_W-1:0] count_all;
  logic [NCH-1:0]            pend_all;

  // ---------------------------------------------------------------------------
  // Timer channels
  // ---------------------------------------------------------------------------
  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic [3:0]       ctrl_q;
    logic [CNT_W-1:0] preset_q;
    logic [CNT_W-1:0] count_q;
    logic             pend_q;
    state_e           state_q;

    logic             sel;
    logic             ctrl_we;
    logic             preset_we;
    logic             ack;
    logic             enable;
    logic             auto_reload;
    logic             count_zero;

    assign sel         = in_ch && (ch_sel == CHW'(n));
    assign ctrl_we     = WE && sel && (reg_sel == REG_CTRL);
    assign preset_we   = WE && sel && (reg_sel == REG_PRESET);
    // W1C acknowledge of this channel's pending flag.
    assign ack         = status_we && Din[n];
    assign enable      = ctrl_q[0];
    // Modes 10/11 are stored as written but run exactly like one-shot.
    assign auto_reload = (ctrl_q[2:1] == 2'b01);
    assign count_zero  = (count_q == '0);

    // PRESET holds the reload value; it never disturbs a count in flight.
    always_ff @(posedge clk) begin
      if (reset) begin
        preset_q <= '0;
      end else if (preset_we) begin
        preset_q <= Din[CNT_W-1:0];
      end
    end

    // Channel FSM with CTRL, COUNT and pending; a CTRL write overrides the
    // sequencer (including the one-shot Enable clear) and restarts from IDLE.
    always_ff @(posedge clk) begin
      if (reset) begin
        ctrl_q  <= '0;
        count_q <= '0;
        pend_q  <= 1'b0;
        state_q <= S_IDLE;
      end else if (ctrl_we) begin
        ctrl_q  <= Din[3:0];
        pend_q  <= 1'b0;
        state_q <= S_IDLE;
      end else begin
        // Acknowledge first so a same-edge hardware set below takes effect.
        if (ack) begin
          pend_q <= 1'b0;
        end
        case (state_q)
          S_IDLE: begin
            if (enable) begin
              state_q <= S_LOAD;
            end
          end
          S_LOAD: begin
            count_q <= preset_q;
            state_q <= S_CNT;
          end
          S_CNT: begin
            if (!enable) begin
              state_q <= S_IDLE;
            end else if (!count_zero) begin
              count_q <= count_q - CNT_W'(1);
            end else begin
              pend_q  <= 1'b1;
              state_q <= S_INT;
            end
          end
          S_INT: begin
            if (auto_reload) begin
              state_q <= S_LOAD;
            end else begin
              ctrl_q[0] <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end

    assign IRQ[n]        = pend_q & ctrl_q[3];
    assign ctrl_all[n]   = ctrl_q;
    assign preset_all[n] = preset_q;
    assign count_all[n]  = count_q;
    assign pend_all[n]   = pend_q;
  end : g_ch

  assign IRQ_any = |IRQ;

  // ---------------------------------------------------------------------------
  // Read mux: unmapped and reserved words return zero
  // ---------------------------------------------------------------------------
  // Combinational read of the addressed register.
  always_comb begin
    Dout = '0;
    if (in_ch) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_sel == CHW'(i)) begin
          case (reg_sel)
            REG_CTRL:   Dout = {28'd0, ctrl_all[i]};
            REG_PRESET: Dout = 32'(preset_all[i]);
            REG_COUNT:  Dout = 32'(count_all[i]);
            default:    Dout = '0;
          endcase
        end
      end
    end else if (status_sel) begin
      Dout = 32'(pend_all);
    end
  end

endmodule

// File: tb/tb_multi_timer.sv
// tb_multi_timer: directed stimulus with a queued scoreboard for two multi_timer configurations.
// Stimulus pushes expectations; a negedge monitor pops and compares them against the DUT outputs.
// Inputs change only after the monitor has sampled, so each expectation sees one stable cycle.
module tb_multi_timer;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:2] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic [1:0]  irq;
    logic        irq_any;

    logic [31:2] addr2;
    logic        we2;
    logic [31:0] din2;
    logic [31:0] dout2;
    logic [3:0]  irq2;
    logic        irq_any2;

    multi_timer #(.NCH(2), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .Addr(addr), .WE(we), .Din(din),
        .Dout(dout), .IRQ(irq), .IRQ_any(irq_any)
    );

    multi_timer #(.NCH(4), .CNT_W(8)) dut2 (
        .clk(clk), .reset(reset), .Addr(addr2), .WE(we2), .Din(din2),
        .Dout(dout2), .IRQ(irq2), .IRQ_any(irq_any2)
    );

    localparam int DOUT  = 0;
    localparam int IRQV  = 1;
    localparam int IRQA  = 2;
    localparam int DOUT2 = 3;
    localparam int IRQV2 = 4;
    localparam int IRQA2 = 5;

    int          src_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          done  = 1'b0;

    always @(negedge clk) begin
        int          s;
        logic [31:0] e;
        logic [31:0] a;
        string       nm;
        while (src_q.size() > 0) begin
            s  = src_q.pop_front();
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            case (s)
                DOUT:    a = dout;
                IRQV:    a = {30'd0, irq};
                IRQA:    a = {31'd0, irq_any};
                DOUT2:   a = dout2;
                IRQV2:   a = {28'd0, irq2};
                default: a = {31'd0, irq_any2};
            endcase
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, a, e);
            end
        end
    end

    initial begin
        #100000;
        if (!done) begin
            n_bad++;
            $display("FAIL timeout: stimulus did not complete within the wait limit");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input int src, input logic [31:0] e, input string nm);
        src_q.push_back(src);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic rd(input int a, input logic [31:0] e, input string nm);
        addr = 30'(a);
        chk(DOUT, e, nm);
    endtask

    task automatic rd2(input int a, input logic [31:0] e, input string nm);
        addr2 = 30'(a);
        chk(DOUT2, e, nm);
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        @(negedge clk);
        #1;
        addr = 30'(a);
        din  = d;
        we   = 1'b1;
        tick();
        we   = 1'b0;
    endtask

    task automatic wr2(input int a, input logic [31:0] d);
        @(negedge clk);
        #1;
        addr2 = 30'(a);
        din2  = d;
        we2   = 1'b1;
        tick();
        we2   = 1'b0;
    endtask

    initial begin
        int cnt_os [8];
        int cnt_ar [18];
        cnt_os = '{0, 5, 4, 3, 2, 1, 0, 0};
        cnt_ar = '{0, 3, 2, 1, 0, 0, 0, 3, 2, 1, 0, 0, 0, 3, 2, 1, 0, 0};

        reset = 1'b1; addr = '0; we = 1'b0; din = '0;
        addr2 = '0; we2 = 1'b0; din2 = '0;
        repeat (3) tick();
        reset = 1'b0;

        n_cmp++;
        if (irq !== 2'b00 || irq_any !== 1'b0 || irq2 !== 4'b0000 || irq_any2 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state_direct: irq=%b irq_any=%b irq2=%b irq_any2=%b",
                     irq, irq_any, irq2, irq_any2);
        end

        rd(0, 32'h0, "rst_ctrl0"); chk(IRQV, 32'h0, "rst_irq"); chk(IRQA, 32'h0, "rst_irq_any");
        tick();
        rd(1, 32'h0, "rst_preset0"); rd2(16, 32'h0, "rst_n4_status"); chk(IRQA2, 32'h0, "rst_n4_irq_any");
        tick();
        rd(2, 32'h0, "rst_count0");
        tick();
        rd(8, 32'h0, "rst_status");
        tick();

        wr(1, 32'd5);
        wr(0, 32'h9);
        addr = 30'd2;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk(DOUT, 32'(cnt_os[k-1]), $sformatf("os_count_E%0d", k));
            chk(IRQV, (k == 8) ? 32'd1 : 32'd0, $sformatf("os_irq_E%0d", k));
        end
        tick();
        rd(0, 32'h8, "os_ctrl_enable_cleared"); chk(IRQV, 32'd1, "os_irq_held"); chk(IRQA, 32'd1, "os_irq_any");
        tick();
        rd(2, 32'h0, "os_count_zero");
        tick();
        rd(32'h108, 32'h1, "status_upper_addr_ignored");
        tick();
        rd(9, 32'h0, "unmapped_word9");
        tick();
        rd(1, 32'd5, "os_preset_readback");
        wr(3, 32'hFFFF_FFFF);
        rd(3, 32'h0, "reserved_word_zero"); chk(IRQV, 32'd1, "os_irq_still_held");
        wr(8, 32'h1);
        rd(8, 32'h0, "os_ack_status"); chk(IRQV, 32'd0, "os_ack_irq"); chk(IRQA, 32'd0, "os_ack_irq_any");

        wr(4, 32'hFFFF_FFFC);
        rd(4, 32'hC, "ctrl_upper_bits_zero");

        wr(5, 32'd3);
        wr(4, 32'hB);
        for (int k = 1; k <= 18; k++) begin
            if (k == 8 || k == 14) wr(8, 32'h2);
            else tick();
            addr = 30'd6;
            chk(DOUT, 32'(cnt_ar[k-1]), $sformatf("ar_count_E%0d", k));
            chk(IRQV, (k == 6 || k == 7 || k == 12 || k == 13 || k == 18) ? 32'd2 : 32'd0,
                $sformatf("ar_irq_E%0d", k));
        end
        wr(4, 32'h0);
        chk(IRQV, 32'd0, "ar_stop_clears_pend");

        wr(1, 32'd2);
        wr(0, 32'h1);
        addr = 30'd8;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk(DOUT, (k == 5) ? 32'd1 : 32'd0, $sformatf("mask_status_E%0d", k));
            chk(IRQV, 32'd0, $sformatf("mask_irq_E%0d", k));
        end
        chk(IRQA, 32'd0, "mask_irq_any");
        tick();
        rd(8, 32'h1, "mask_status_held");
        wr(0, 32'h8);
        rd(8, 32'h0, "mask_ctrl_write_clears");

        wr(1, 32'd2);
        wr(0, 32'h9);
        repeat (4) tick();
        wr(8, 32'h1);
        rd(8, 32'h1, "coll_set_wins"); chk(IRQV, 32'd1, "coll_irq");
        wr(8, 32'h2);
        rd(8, 32'h1, "w1c_zero_bit_no_effect");
        wr(8, 32'h1);
        rd(8, 32'h0, "coll_cleared"); chk(IRQA, 32'd0, "coll_irq_any_low");

        wr(1, 32'd20);
        wr(0, 32'h1);
        repeat (12) tick();
        rd(2, 32'd10, "dis_count_before");
        wr(0, 32'h0);
        rd(2, 32'd10, "dis_count_at_write");
        repeat (4) tick();
        rd(2, 32'd10, "dis_count_held");
        tick();
        rd(0, 32'h0, "dis_ctrl");

        wr(5, 32'd0);
        wr(4, 32'h9);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk(IRQV, (k == 3) ? 32'd2 : 32'd0, $sformatf("p0_irq_E%0d", k));
        end

        wr(1, 32'd6);
        wr(0, 32'h9);
        repeat (4) tick();
        rd(2, 32'd4, "pre_rst_count"); chk(IRQV, 32'd2, "pre_rst_irq");
        @(negedge clk);
        #1;
        reset = 1'b1; we = 1'b1; addr = 30'd1; din = 32'h55;
        tick();
        reset = 1'b0; we = 1'b0;
        chk(IRQA, 32'd0, "rst_mid_irq_any"); chk(IRQV, 32'd0, "rst_mid_irq");
        tick();
        rd(1, 32'h0, "rst_beats_we");
        tick();
        rd(2, 32'h0, "rst_mid_count");
        tick();
        rd(0, 32'h0, "rst_mid_ctrl0");
        tick();
        rd(4, 32'h0, "rst_mid_ctrl1");
        tick();
        rd(8, 32'h0, "rst_mid_status");
        tick();

        wr2(1, 32'h1FF);
        rd2(1, 32'hFF, "n4_preset_trunc");
        wr2(13, 32'h0);
        wr2(12, 32'h9);
        repeat (3) tick();
        rd2(16, 32'h8, "n4_status_word16"); chk(IRQV2, 32'h8, "n4_irq"); chk(IRQA2, 32'h1, "n4_irq_any");
        tick();
        rd2(17, 32'h0, "n4_word17_zero");
        tick();
        tick();

        done = 1'b1;
        if (src_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover_expectations: %0d not compared", src_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
